// File: rtl/conv_read_addr_gen_if.sv
// Handshake and configuration bundle between design_controller and the
// window read-address generator.
interface conv_read_addr_gen_if #(
    parameter int IF_ADDR_LEN   = 4,
    parameter int FILT_ADDR_LEN = 4,
    parameter int ROW_W         = 2
);
    logic                     start_rd_gen;
    logic                     clear_regs;
    logic                     reset_all;
    logic                     reset_Filter;
    logic                     go_next_row;
    logic                     usage_stride_pos_ld;
    logic [IF_ADDR_LEN:0]     if_len;
    logic [FILT_ADDR_LEN:0]   filt_len;
    logic [IF_ADDR_LEN-1:0]   stride;
    logic [ROW_W:0]           num_rows;
    logic [IF_ADDR_LEN:0]     if_avail;

    logic [IF_ADDR_LEN-1:0]   if_raddr;
    logic [FILT_ADDR_LEN-1:0] filt_raddr;
    logic                     rd_valid;
    logic [ROW_W-1:0]         row_sel;
    logic                     psum_done;
    logic                     stride_count_flag;
    logic                     stride_pos_ld;
    logic                     full_done;

    modport master (
        output start_rd_gen, clear_regs, reset_all, reset_Filter, go_next_row,
               usage_stride_pos_ld, if_len, filt_len, stride, num_rows, if_avail,
        input  if_raddr, filt_raddr, rd_valid, row_sel, psum_done,
               stride_count_flag, stride_pos_ld, full_done
    );

    modport slave (
        input  start_rd_gen, clear_regs, reset_all, reset_Filter, go_next_row,
               usage_stride_pos_ld, if_len, filt_len, stride, num_rows, if_avail,
        output if_raddr, filt_raddr, rd_valid, row_sel, psum_done,
               stride_count_flag, stride_pos_ld, full_done
    );
endinterface

// File: rtl/conv_read_addr_gen.sv
// Window read-address generator: walks base+k over each convolution window,
// steps the window base by the stride and reports window/row/pass completion.
//
// state    | meaning
// IDLE     | waiting for start_rd_gen; base retained
// RUN      | issuing taps k=0..K-1 as IF data becomes available
// WAIT_CLR | all taps issued, waiting for clear_regs
// ROW_END  | one-cycle row completion (stride_pos_ld / full_done)
module conv_read_addr_gen #(
    parameter int IF_ADDR_LEN   = 4,
    parameter int FILT_ADDR_LEN = 4,
    parameter int ROW_W         = 2
) (
    input logic clk,
    input logic rst,
    conv_read_addr_gen_if.slave bus
);
    // Wide enough that base+stride+K can never overflow in the fit checks.
    localparam int SW = ((IF_ADDR_LEN > FILT_ADDR_LEN) ? IF_ADDR_LEN : FILT_ADDR_LEN) + 3;
    localparam logic [FILT_ADDR_LEN:0] K_ONE   = 1;
    localparam logic [ROW_W:0]         ROW_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, WAIT_CLR, ROW_END} state_t;

    state_t                   state_q, state_d;
    logic [IF_ADDR_LEN-1:0]   base_q, base_d;
    logic [FILT_ADDR_LEN:0]   k_q, k_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic                     last_q, last_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [IF_ADDR_LEN-1:0]   if_raddr_q, if_raddr_d;
    logic [FILT_ADDR_LEN-1:0] filt_raddr_q, filt_raddr_d;
    logic                     psum_done_q, psum_done_d;
    logic                     scf_q, scf_d;
    logic                     spl_q, spl_d;
    logic                     full_q, full_d;

    logic [SW-1:0] base_w, k_w, klen_w, n_w, avail_w, step_w, cur_w, nb_w;
    logic [ROW_W:0] row_inc;

    assign base_w  = SW'(base_q);
    assign k_w     = SW'(k_q);
    assign klen_w  = SW'(bus.filt_len);
    assign n_w     = SW'(bus.if_len);
    assign avail_w = SW'(bus.if_avail);
    assign step_w  = (bus.stride == '0) ? SW'(1) : SW'(bus.stride);
    assign cur_w   = base_w + k_w;
    assign nb_w    = base_w + step_w;
    assign row_inc = {1'b0, row_q} + ROW_ONE;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        k_d          = k_q;
        row_d        = row_q;
        last_d       = 1'b0;
        rd_valid_d   = 1'b0;
        if_raddr_d   = if_raddr_q;
        filt_raddr_d = filt_raddr_q;
        psum_done_d  = last_q;
        scf_d        = 1'b0;
        spl_d        = 1'b0;
        full_d       = 1'b0;

        if (bus.reset_all) begin
            state_d      = IDLE;
            base_d       = '0;
            k_d          = '0;
            row_d        = '0;
            if_raddr_d   = '0;
            filt_raddr_d = '0;
            psum_done_d  = 1'b0;
        end else begin
            if (bus.go_next_row) begin
                row_d       = (row_inc >= bus.num_rows) ? '0 : row_inc[ROW_W-1:0];
                base_d      = '0;
                k_d         = '0;
                state_d     = IDLE;
                psum_done_d = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start_rd_gen) begin
                            k_d     = '0;
                            state_d = (base_w + klen_w > n_w) ? ROW_END : RUN;
                        end
                    end
                    RUN: begin
                        if (cur_w < avail_w) begin
                            rd_valid_d   = 1'b1;
                            if_raddr_d   = cur_w[IF_ADDR_LEN-1:0];
                            filt_raddr_d = k_q[FILT_ADDR_LEN-1:0];
                            k_d          = k_q + K_ONE;
                            if (k_w + SW'(1) >= klen_w) begin
                                last_d  = 1'b1;
                                state_d = WAIT_CLR;
                            end
                        end
                    end
                    WAIT_CLR: begin
                        if (bus.clear_regs) begin
                            if (nb_w + klen_w <= n_w) begin
                                base_d  = nb_w[IF_ADDR_LEN-1:0];
                                k_d     = '0;
                                scf_d   = 1'b1;
                                state_d = RUN;
                            end else begin
                                state_d = ROW_END;
                            end
                        end
                    end
                    ROW_END: begin
                        spl_d   = 1'b1;
                        full_d  = (row_inc == bus.num_rows);
                        if (bus.usage_stride_pos_ld) begin
                            base_d = '0;
                        end
                        state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
            if (bus.reset_Filter) begin
                k_d          = '0;
                filt_raddr_d = '0;
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            k_q          <= '0;
            row_q        <= '0;
            last_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            if_raddr_q   <= '0;
            filt_raddr_q <= '0;
            psum_done_q  <= 1'b0;
            scf_q        <= 1'b0;
            spl_q        <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            k_q          <= k_d;
            row_q        <= row_d;
            last_q       <= last_d;
            rd_valid_q   <= rd_valid_d;
            if_raddr_q   <= if_raddr_d;
            filt_raddr_q <= filt_raddr_d;
            psum_done_q  <= psum_done_d;
            scf_q        <= scf_d;
            spl_q        <= spl_d;
            full_q       <= full_d;
        end
    end

    assign bus.rd_valid          = rd_valid_q;
    assign bus.if_raddr          = if_raddr_q;
    assign bus.filt_raddr        = filt_raddr_q;
    assign bus.row_sel           = row_q;
    assign bus.psum_done         = psum_done_q;
    assign bus.stride_count_flag = scf_q;
    assign bus.stride_pos_ld     = spl_q;
    assign bus.full_done         = full_q;
endmodule

// File: doc/conv_read_addr_gen.md
Name: conv_read_addr_gen

Overview:
Window read-address generator for the PE datapath. It sits directly downstream of design_controller and consumes start_rd_gen, clear_regs, reset_all, reset_Filter, go_next_row and usage_stride_pos_ld. It drives IF/filter scratchpad read addresses for each convolution window. It returns psum_done, stride_count_flag, stride_pos_ld and full_done to the controller.

Parameters:
IF_ADDR_LEN, 4, IF scratchpad address width (N ≤ 2^IF_ADDR_LEN)
FILT_ADDR_LEN, 4, filter scratchpad address width (K ≤ 2^FILT_ADDR_LEN)
ROW_W, 2, width of row index / row count

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start_rd_gen  in  1  begin/continue window generation
clear_regs  in  1  window accumulated; advance to next window
reset_all  in  1  synchronous full clear (priority over all other inputs)
reset_Filter  in  1  synchronous clear of filter base to 0
go_next_row  in  1  advance row_sel, restart base at 0
usage_stride_pos_ld  in  1  1: reload base to 0 at row end; 0: hold base
if_len  in  IF_ADDR_LEN+1  N, IF elements per row
filt_len  in  FILT_ADDR_LEN+1  K, taps per window (≥1)
stride  in  IF_ADDR_LEN  stride S (0 treated as 1)
num_rows  in  ROW_W+1  rows per full pass (≥1)
if_avail  in  IF_ADDR_LEN+1  IF words already written
if_raddr  out  IF_ADDR_LEN  IF read address = base + k
filt_raddr  out  FILT_ADDR_LEN  filter read address = k
rd_valid  out  1  read issued this cycle
row_sel  out  ROW_W  current row
psum_done  out  1  1-cycle pulse: window taps all issued
stride_count_flag  out  1  1-cycle pulse: base advanced by S
stride_pos_ld  out  1  1-cycle pulse: last window of row finished
full_done  out  1  1-cycle pulse: last window of last row finished

Behaviour:
- Reset (rst=0) or reset_all=1: state IDLE, base=0, k=0, row_sel=0, all outputs 0.
- States: IDLE, RUN, WAIT_CLR, ROW_END.
- IDLE: on start_rd_gen go to RUN with k=0; base is kept. If base+K > N, go to ROW_END instead, with no reads.
- RUN, read issue: when base+k < if_avail, set rd_valid=1, drive if_raddr=base+k and filt_raddr=k, then k++.
- RUN, stall: when base+k ≥ if_avail, rd_valid=0 and k holds.
- RUN, last tap: after the read with k=K-1, pulse psum_done on the next cycle and enter WAIT_CLR.
- WAIT_CLR: wait for clear_regs. On clear_regs, compute nb = base+S in IF_ADDR_LEN+2 bits.
  - If nb+K ≤ N: base=nb, k=0, pulse stride_count_flag, go to RUN.
  - Otherwise go to ROW_END.
- ROW_END: one cycle.
  - Pulse stride_pos_ld.
  - Pulse full_done if row_sel==num_rows-1.
  - If usage_stride_pos_ld, base=0; otherwise base holds.
  - Next state is IDLE.
- go_next_row (any state except during reset_all): row_sel++ (wraps at num_rows-1 → 0), base=0, k=0, state IDLE.
- reset_Filter: k=0 and filt_raddr=0 next cycle; base and state unaffected.
- Priority: reset_all > go_next_row > clear_regs > start_rd_gen.
- start_rd_gen outside IDLE is ignored. clear_regs outside WAIT_CLR is ignored.
- Address arithmetic is unsigned with no wrap. Window-fit checks use the widened sums, so no truncated compare is possible.
- Outputs are registered: rd_valid/addresses appear 1 cycle after the state/counter update that issues them. psum_done follows the last rd_valid by exactly 1 cycle.

Test Plan:
1. N=8, K=3, S=1, num_rows=1, if_avail=8, start_rd_gen, clear_regs echoes psum_done.
   - 6 windows; if_raddr sequences 0,1,2 / 1,2,3 … 5,6,7.
   - 5 stride_count_flag pulses, then stride_pos_ld and full_done together.
2. N=9, K=3, S=2: bases 0,2,4,6, then row end.
   - The window at base 8 is rejected (8+3 > 9).
3. if_avail=2 with N=8, K=3: rd_valid for addresses 0,1, then stall.
   - Raise if_avail to 8: address 2 issues the next cycle and psum_done follows.
4. K=5, N=4: start_rd_gen gives zero rd_valid.
   - stride_pos_ld and full_done pulse together within 2 cycles.
5. num_rows=2, usage_stride_pos_ld=0.
   - Row 0 end gives stride_pos_ld only; go_next_row sets row_sel=1 and base=0.
   - Row 1 end gives full_done.
6. reset_all mid-window, and separately rst=0 asynchronously.
   - Outputs are 0 and state is IDLE immediately (rst) or next edge (reset_all).
   - A new start restarts at if_raddr=0.
